// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Shares the single register-file write port between the pipeline
//   write-back stage and the multi-cycle mult/div unit (MDU).
//   - WB always has priority.
//   - MDU results wait in a small FIFO and drain on cycles when WB is idle.
//   - A starvation timer raises stall_req so that a queued MDU result is
//     guaranteed to drain.
//
// Optional feature:
//   WB_ARB_BYPASS_EN - when defined, an MDU result that arrives while the
//   FIFO is empty and WB is not granted goes straight to rf_* (1-cycle
//   latency) and is not pushed. When undefined, every MDU result is queued.
//
// Parameters:
//   DATA_W      register data width
//   REG_AW      register address width
//   FIFO_DEPTH  MDU result queue entries (power of two, >= 2)
//   STARVE_MAX  consecutive un-granted cycles before stall_req (>= 1)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous reset, active low
//   wb_we      in   WB-stage register write request
//   wb_addr    in   WB destination register
//   wb_data    in   WB write data
//   mdu_valid  in   MDU result valid
//   mdu_addr   in   MDU destination register
//   mdu_data   in   MDU result
//   mdu_ready  out  FIFO can accept (push = mdu_valid & mdu_ready)
//   rf_we      out  register-file write enable (registered)
//   rf_addr    out  register-file write address (registered)
//   rf_data    out  register-file write data (registered)
//   stall_req  out  freeze pipeline, WB holds wb_* stable (registered)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mdu_valid,
  input  logic [REG_AW-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              stall_req
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int SCNT_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [SCNT_W-1:0] STARVE_LIM = SCNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    STARVED
  } state_t;

  state_t state;

  logic [REG_AW-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_vld;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [SCNT_W-1:0] starve_cnt;

  logic fifo_empty;
  logic wb_grant;
  logic pop;
  logic head_vld;
  logic push;
  logic bypass;
  logic starve_hit;

  assign fifo_empty = (count == '0);
  assign mdu_ready  = rst_n & (count != FULL_CNT);

  // WB wins unless the pipeline is frozen; a write to r0 is never a request.
  assign wb_grant = wb_we & ~stall_req & (wb_addr != '0);

  // The head is popped whenever WB does not take the port. A killed head
  // still pops, it just produces no register-file write.
  assign pop      = ~wb_grant & ~fifo_empty;
  assign head_vld = q_vld[rd_ptr];

`ifdef WB_ARB_BYPASS_EN
  assign bypass = mdu_valid & fifo_empty & ~wb_grant & (mdu_addr != '0);
`else
  assign bypass = 1'b0;
`endif

  // r0 results complete the handshake but are dropped here.
  assign push = mdu_valid & mdu_ready & (mdu_addr != '0) & ~bypass;

  // The starve counter never rests at the limit in DRAIN: reaching it moves
  // the FSM to STARVED, which always pops and clears the count.
  assign starve_hit = (state == DRAIN) & ~pop & (starve_cnt == STARVE_LIM - 1'b1);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  // FIFO storage. The WAW kill runs before the push write, so an entry
  // pushed in the same cycle as a matching WB grant survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q_vld  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (wb_grant) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          if (q_addr[i] == wb_addr) begin
            q_vld[i] <= 1'b0;
          end
        end
      end
      if (push) begin
        q_addr[wr_ptr] <= mdu_addr;
        q_data[wr_ptr] <= mdu_data;
        q_vld[wr_ptr]  <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
    end
  end

  // Control FSM with registered write-port and stall outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      stall_req  <= 1'b0;
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_data    <= '0;
    end else begin
      rf_we <= 1'b0;
      if (wb_grant) begin
        rf_we   <= 1'b1;
        rf_addr <= wb_addr;
        rf_data <= wb_data;
      end else if (pop) begin
        if (head_vld) begin
          rf_we   <= 1'b1;
          rf_addr <= q_addr[rd_ptr];
          rf_data <= q_data[rd_ptr];
        end
      end else if (bypass) begin
        rf_we   <= 1'b1;
        rf_addr <= mdu_addr;
        rf_data <= mdu_data;
      end

      if (pop) begin
        starve_cnt <= '0;
      end else if (state == DRAIN && starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          stall_req <= 1'b0;
          if (push) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && count_next == '0) begin
            state     <= IDLE;
            stall_req <= 1'b0;
          end else if (starve_hit) begin
            state     <= STARVED;
            stall_req <= 1'b1;
          end
        end
        STARVED: begin
          // WB is blocked by stall_req, so the head pops this cycle.
          stall_req <= 1'b0;
          state     <= (count_next == '0) ? IDLE : DRAIN;
        end
        default: begin
          state     <= IDLE;
          stall_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Directed testbench for wb_port_arbiter (default parameters: DATA_W=32,
// REG_AW=5, FIFO_DEPTH=2, STARVE_MAX=4). Inputs change on the falling edge;
// outputs are observed on the falling edge, half a cycle after the rising
// edge that produced them.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        stall_req;

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .mdu_valid (mdu_valid),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .mdu_ready (mdu_ready),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  // Advance one full cycle: the rising edge happens, then we sit on the
  // following falling edge where outputs are stable.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_we     = 1'b0;
    wb_addr   = 5'd0;
    wb_data   = 32'h0;
    mdu_valid = 1'b0;
    mdu_addr  = 5'd0;
    mdu_data  = 32'h0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    wb_we     = 1'b1;
    wb_addr   = 5'd3;
    wb_data   = 32'h1234;
    mdu_valid = 1'b1;
    mdu_addr  = 5'd5;
    mdu_data  = 32'h5678;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (rf_we !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_rf_we cycle %0d: got %b expected 0", c, rf_we);
      end
      n_checks++;
      if (stall_req !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_stall cycle %0d: got %b expected 0", c, stall_req);
      end
      n_checks++;
      if (mdu_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_mdu_ready cycle %0d: got %b expected 0", c, mdu_ready);
      end
    end
    idle_inputs();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (mdu_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL release_mdu_ready: got %b expected 1", mdu_ready);
    end
    n_checks++;
    if (rf_addr !== 5'd0 || rf_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_rf_regs: got addr %0d data %h expected 0/0", rf_addr, rf_data);
    end
    step();
  endtask

  task automatic test_priority();
    wb_we     = 1'b1;
    wb_addr   = 5'd3;
    wb_data   = 32'h11;
    mdu_valid = 1'b1;
    mdu_addr  = 5'd5;
    mdu_data  = 32'h22;
    step();
    idle_inputs();
    n_checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd3 || rf_data !== 32'h11) begin
      n_fail++;
      $display("[TB] FAIL prio_wb_first: got we %b r%0d=%h expected we 1 r3=11", rf_we, rf_addr, rf_data);
    end
    step();
    n_checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'h22) begin
      n_fail++;
      $display("[TB] FAIL prio_mdu_second: got we %b r%0d=%h expected we 1 r5=22", rf_we, rf_addr, rf_data);
    end
    step();
    n_checks++;
    if (rf_we !== 1'b0 || rf_addr !== 5'd5 || rf_data !== 32'h22) begin
      n_fail++;
      $display("[TB] FAIL prio_hold: got we %b r%0d=%h expected we 0 r5=22", rf_we, rf_addr, rf_data);
    end
  endtask

  task automatic test_starvation();
    wb_we     = 1'b1;
    wb_addr   = 5'd1;
    wb_data   = 32'h100;
    mdu_valid = 1'b1;
    mdu_addr  = 5'd7;
    mdu_data  = 32'h77;
    step();
    mdu_valid = 1'b0;
    n_checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd1) begin
      n_fail++;
      $display("[TB] FAIL starve_wb_write: got we %b r%0d expected we 1 r1", rf_we, rf_addr);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      n_checks++;
      if (stall_req !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL starve_early_stall cycle %0d: got %b expected 0", c, stall_req);
      end
    end
    step();
    n_checks++;
    if (stall_req !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL starve_stall_on: got %b expected 1", stall_req);
    end
    step();
    n_checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd7 || rf_data !== 32'h77) begin
      n_fail++;
      $display("[TB] FAIL starve_drain: got we %b r%0d=%h expected we 1 r7=77", rf_we, rf_addr, rf_data);
    end
    n_checks++;
    if (stall_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL starve_stall_off: got %b expected 0", stall_req);
    end
    step();
    n_checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd1 || rf_data !== 32'h100) begin
      n_fail++;
      $display("[TB] FAIL starve_wb_resume: got we %b r%0d=%h expected we 1 r1=100", rf_we, rf_addr, rf_data);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_full();
    wb_we     = 1'b1;
    wb_addr   = 5'd2;
    wb_data   = 32'h200;
    mdu_valid = 1'b1;
    mdu_addr  = 5'd10;
    mdu_data  = 32'hA0;
    #1;
    n_checks++;
    if (mdu_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL full_ready_first: got %b expected 1", mdu_ready);
    end
    step();
    mdu_addr = 5'd11;
    mdu_data = 32'hA1;
    #1;
    n_checks++;
    if (mdu_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL full_ready_second: got %b expected 1", mdu_ready);
    end
    step();
    mdu_addr = 5'd12;
    mdu_data = 32'hA2;
    #1;
    n_checks++;
    if (mdu_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_ready_third: got %b expected 0", mdu_ready);
    end
    step();
    n_checks++;
    if (mdu_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_ready_held: got %b expected 0", mdu_ready);
    end
    wb_we = 1'b0;
    step();
    n_checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd10 || rf_data !== 32'hA0) begin
      n_fail++;
      $display("[TB] FAIL full_pop1: got we %b r%0d=%h expected we 1 r10=a0", rf_we, rf_addr, rf_data);
    end
    n_checks++;
    if (mdu_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL full_ready_after_pop: got %b expected 1", mdu_ready);
    end
    step();
    mdu_valid = 1'b0;
    n_checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd11 || rf_data !== 32'hA1) begin
      n_fail++;
      $display("[TB] FAIL full_pop2: got we %b r%0d=%h expected we 1 r11=a1", rf_we, rf_addr, rf_data);
    end
    step();
    n_checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd12 || rf_data !== 32'hA2) begin
      n_fail++;
      $display("[TB] FAIL full_pop3: got we %b r%0d=%h expected we 1 r12=a2", rf_we, rf_addr, rf_data);
    end
    idle_inputs();
    step();
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_empty_after: got we %b expected 0", rf_we);
    end
  endtask

  task automatic test_waw_kill();
    wb_we     = 1'b1;
    wb_addr   = 5'd1;
    wb_data   = 32'h01;
    mdu_valid = 1'b1;
    mdu_addr  = 5'd9;
    mdu_data  = 32'hAA;
    step();
    mdu_valid = 1'b0;
    wb_addr   = 5'd9;
    wb_data   = 32'hBB;
    step();
    wb_we = 1'b0;
    n_checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd9 || rf_data !== 32'hBB) begin
      n_fail++;
      $display("[TB] FAIL waw_wb_write: got we %b r%0d=%h expected we 1 r9=bb", rf_we, rf_addr, rf_data);
    end
    step();
    n_checks++;
    if (rf_we !== 1'b0 || rf_addr !== 5'd9 || rf_data !== 32'hBB) begin
      n_fail++;
      $display("[TB] FAIL waw_killed_pop: got we %b r%0d=%h expected we 0 r9=bb", rf_we, rf_addr, rf_data);
    end
    step();
    n_checks++;
    if (rf_we !== 1'b0 || rf_data !== 32'hBB) begin
      n_fail++;
      $display("[TB] FAIL waw_quiet: got we %b data %h expected we 0 data bb", rf_we, rf_data);
    end
    idle_inputs();
  endtask

  task automatic test_r0_bypass();
    mdu_valid = 1'b1;
    mdu_addr  = 5'd0;
    mdu_data  = 32'hDEAD;
    #1;
    n_checks++;
    if (mdu_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL r0_mdu_ready: got %b expected 1", mdu_ready);
    end
    step();
    mdu_valid = 1'b0;
    wb_we     = 1'b1;
    wb_addr   = 5'd0;
    wb_data   = 32'hBEEF;
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL r0_mdu_no_write: got we %b expected 0", rf_we);
    end
    step();
    wb_we = 1'b0;
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL r0_wb_no_write: got we %b expected 0", rf_we);
    end
    step();
    n_checks++;
    if (rf_we !== 1'b0 || rf_data === 32'hDEAD) begin
      n_fail++;
      $display("[TB] FAIL r0_not_queued: got we %b data %h expected we 0 and no dead", rf_we, rf_data);
    end
    mdu_valid = 1'b1;
    mdu_addr  = 5'd4;
    mdu_data  = 32'h44;
    step();
    mdu_valid = 1'b0;
`ifdef WB_ARB_BYPASS_EN
    n_checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd4 || rf_data !== 32'h44) begin
      n_fail++;
      $display("[TB] FAIL bypass_write: got we %b r%0d=%h expected we 1 r4=44", rf_we, rf_addr, rf_data);
    end
    step();
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bypass_not_queued: got we %b expected 0", rf_we);
    end
`else
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL queued_latency1: got we %b expected 0", rf_we);
    end
    step();
    n_checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd4 || rf_data !== 32'h44) begin
      n_fail++;
      $display("[TB] FAIL queued_latency2: got we %b r%0d=%h expected we 1 r4=44", rf_we, rf_addr, rf_data);
    end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_starvation();
    test_full();
    test_waw_kill();
    test_r0_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
